pe_os_chain: RTL

PE_OS_CHAIN -- requirements
Module: pe_os_chain

---
 rtl/pe_os_chain.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pe_os_chain.sv
// Output-stationary MAC processing element with a daisy-chained drain port.
// Operands stream right/down through registered forwarding. Matched operand
// pairs accumulate locally until a tile's final beat; the clamped or truncated
// result is then offered on the drain port. A non-head PE then passes beats
// from upstream through until the head's last beat goes by.
module pe_os_chain #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned OUT_W  = 32,
  parameter bit          SIGNED = 1'b1,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_row_data,
  input  logic              i_row_valid,
  input  logic [DATA_W-1:0] i_col_data,
  input  logic              i_col_valid,
  input  logic              i_clear,
  input  logic              i_last,
  input  logic              i_chain_head,
  output logic [DATA_W-1:0] o_row_data,
  output logic              o_row_valid,
  output logic [DATA_W-1:0] o_col_data,
  output logic              o_col_valid,
  input  logic [OUT_W-1:0]  i_drain_data,
  input  logic              i_drain_valid,
  input  logic              i_drain_last,
  output logic              o_drain_ready,
  output logic [OUT_W-1:0]  o_drain_data,
  output logic              o_drain_valid,
  output logic              o_drain_last,
  input  logic              i_drain_ready,
  output logic              o_busy,
  output logic              o_sat,
  output logic              o_drop
);

  localparam int unsigned ProdW = 2 * DATA_W;

  localparam logic [OUT_W-1:0] SignedMax   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SignedMin   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UnsignedMax = {OUT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StHold,
    StPass
  } state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic             sat_q, drop_q;

  logic              pair_valid;
  logic              mac_fire;
  logic              drop_hit;
  logic              tile_done;
  logic [ProdW-1:0]  row_ext_u, col_ext_u, prod_u;
  logic signed [ProdW-1:0] row_ext_s, col_ext_s, prod_s;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  acc_hi;
  logic              acc_fits;
  logic              clamp_hit;

  // Beat qualification: MAC only while accumulating, otherwise the pair is lost.
  always_comb begin
    pair_valid = i_row_valid & i_col_valid;
    mac_fire   = pair_valid & ((state_q == StIdle) | (state_q == StAcc));
    drop_hit   = pair_valid & ((state_q == StHold) | (state_q == StPass));
    tile_done  = mac_fire & i_last;
  end

  // Full-precision product, extended to the accumulator width per signedness.
  always_comb begin
    row_ext_s = ProdW'($signed(i_row_data));
    col_ext_s = ProdW'($signed(i_col_data));
    row_ext_u = ProdW'(i_row_data);
    col_ext_u = ProdW'(i_col_data);
    prod_s    = row_ext_s * col_ext_s;
    prod_u    = row_ext_u * col_ext_u;
    if (SIGNED) begin
      prod_ext = ACC_W'(prod_s);
    end else begin
      prod_ext = ACC_W'(prod_u);
    end
  end

  // Accumulator next state; wraps modulo 2^ACC_W.
  always_comb begin
    acc_d = acc_q;
    if (mac_fire) begin
      if (i_clear) begin
        acc_d = prod_ext;
      end else begin
        acc_d = acc_q + prod_ext;
      end
    end
  end

  // Result formatting of the post-beat accumulator: clamp or truncate.
  always_comb begin
    if (SIGNED) begin
      // Fits when every bit above the OUT_W sign bit matches it.
      acc_hi   = ACC_W'($signed(acc_d) >>> (OUT_W - 1));
      acc_fits = (acc_hi == '0) || (acc_hi == '1);
    end else begin
      acc_hi   = acc_d >> OUT_W;
      acc_fits = (acc_hi == '0);
    end
    clamp_hit = SAT_EN && !acc_fits;
    res_d     = acc_d[OUT_W-1:0];
    if (clamp_hit) begin
      if (!SIGNED) begin
        res_d = UnsignedMax;
      end else if (acc_d[ACC_W-1]) begin
        res_d = SignedMin;
      end else begin
        res_d = SignedMax;
      end
    end
  end

  // Operand forwarding, one register stage per stream, in every state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_row_data  <= '0;
      o_row_valid <= 1'b0;
      o_col_data  <= '0;
      o_col_valid <= 1'b0;
    end else begin
      o_row_data  <= i_row_data;
      o_row_valid <= i_row_valid;
      o_col_data  <= i_col_data;
      o_col_valid <= i_col_valid;
    end
  end

  // Datapath state: accumulator, captured result and sticky flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc_q  <= '0;
      res_q  <= '0;
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (tile_done) begin
        res_q <= res_d;
        if (clamp_hit) begin
          sat_q <= 1'b1;
        end
      end
      if (drop_hit) begin
        drop_q <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accumulate, offer own result, then relay upstream beats.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mac_fire) begin
          state_d = i_last ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (tile_done) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (i_drain_ready) begin
          state_d = i_chain_head ? StIdle : StPass;
        end
      end
      StPass: begin
        if (i_drain_valid && i_drain_ready && i_drain_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drain port: own result in HOLD, combinational relay in PASS, quiet otherwise.
  always_comb begin
    o_drain_data  = '0;
    o_drain_valid = 1'b0;
    o_drain_last  = 1'b0;
    o_drain_ready = 1'b0;
    unique case (state_q)
      StHold: begin
        o_drain_data  = res_q;
        o_drain_valid = 1'b1;
        o_drain_last  = i_chain_head;
      end
      StPass: begin
        o_drain_data  = i_drain_data;
        o_drain_valid = i_drain_valid;
        o_drain_last  = i_drain_last;
        o_drain_ready = i_drain_ready;
      end
      default: ;
    endcase
  end

  // Status outputs.
  always_comb begin
    o_busy = (state_q != StIdle);
    o_sat  = sat_q;
    o_drop = drop_q;
  end

endmodule
